// File: rtl/seq_stream_ctrl_pkg.sv
// Shared types and default widths for the serializer / detection-count slice.
package seq_stream_ctrl_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int DEF_WORD_W = 8;
  localparam int DEF_CNT_W  = 16;

  // Width of a down-counter that must hold WORD_W-1; never narrower than 1.
  function automatic int bitcnt_w(input int word_w);
    return (word_w > 1) ? $clog2(word_w) : 1;
  endfunction
endpackage

// File: rtl/seq_stream_ctrl_if.sv
// Word-in handshake between a producer and the serializer.
interface seq_stream_ctrl_if #(parameter int WORD_W = 8);
  logic              in_valid;
  logic [WORD_W-1:0] in_data;
  logic              in_ready;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/seq_stream_ctrl_det_counter.sv
// Saturating detection counter with sticky threshold flag; clear beats a coincident pulse.
module det_counter
  import seq_stream_ctrl_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_cnt_en,
  input  logic             i_det,
  input  logic             i_clear,
  input  logic [CNT_W-1:0] i_threshold,
  output logic [CNT_W-1:0] o_count,
  output logic             o_hit
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] r_count;
  logic             r_hit;
  logic [CNT_W-1:0] w_next;
  logic             w_hit;

  always_comb begin
    w_next = r_count;
    if (i_cnt_en && i_det && (r_count != CNT_MAX)) w_next = r_count + 1'b1;
    // Compare against the post-edge count so a lowered threshold fires immediately.
    w_hit = (i_threshold != '0) && (w_next >= i_threshold);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
      r_hit   <= 1'b0;
    end else if (i_clear) begin
      r_count <= '0;
      r_hit   <= 1'b0;
    end else begin
      r_count <= w_next;
      if (w_hit) r_hit <= 1'b1;
    end
  end

  assign o_count = r_count;
  assign o_hit   = r_hit;
endmodule

// File: rtl/seq_stream_ctrl.sv
// MSB-first word serializer feeding an external Moore detector, with detection counting.
module seq_stream_ctrl
  import seq_stream_ctrl_pkg::*;
#(
  parameter int WORD_W = DEF_WORD_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             enable,
  seq_stream_ctrl_if.slave s_if,
  output logic             seq_out,
  output logic             seq_valid,
  input  logic             det_in,
  input  logic [CNT_W-1:0] threshold,
  input  logic             clear_count,
  output logic [CNT_W-1:0] det_count,
  output logic             thresh_hit,
  output logic             busy
);
  localparam int BW = bitcnt_w(WORD_W);

  state_t            r_state, w_state_nxt;
  logic [WORD_W-1:0] r_shift;
  logic [BW-1:0]     r_bitcnt;
  logic              r_armed;
  logic              w_ready, w_load, w_shift;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ready     = 1'b0;
    w_load      = 1'b0;
    w_shift     = 1'b0;
    case (r_state)
      IDLE: begin
        w_ready = enable & r_armed;
        if (w_ready && s_if.in_valid) begin
          w_load      = 1'b1;
          w_state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        w_shift = 1'b1;
        if (r_bitcnt == '0) begin
          // Last bit: accept the next word here so back-to-back words have no bubble.
          w_ready = enable & r_armed;
          if (w_ready && s_if.in_valid) w_load = 1'b1;
          else                          w_state_nxt = DRAIN;
        end
      end
      DRAIN:   w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_shift  <= '0;
      r_bitcnt <= '0;
    end else if (w_load) begin
      r_shift  <= s_if.in_data;
      r_bitcnt <= BW'(WORD_W - 1);
    end else if (w_shift) begin
      r_shift <= r_shift << 1;
      if (r_bitcnt != '0) r_bitcnt <= r_bitcnt - 1'b1;
    end
  end

  // Holds off in_ready for the first edge after reset release.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_armed <= 1'b0;
    else          r_armed <= 1'b1;
  end

  assign s_if.in_ready = w_ready;
  assign seq_valid     = (r_state == SHIFT);
  assign seq_out       = (r_state == SHIFT) ? r_shift[WORD_W-1] : 1'b0;
  assign busy          = (r_state != IDLE);

  det_counter #(.CNT_W(CNT_W)) u_det_counter (
    .clk         (clock),
    .rst_n       (reset_n),
    .i_cnt_en    (r_state != IDLE),
    .i_det       (det_in),
    .i_clear     (clear_count),
    .i_threshold (threshold),
    .o_count     (det_count),
    .o_hit       (thresh_hit)
  );
endmodule

// File: tb/tb_seq_stream_ctrl.sv
// Scoreboarded bench: expected stream bits queued at handshake, popped by a negedge monitor.
module tb_seq_stream_ctrl;
  logic        clock = 1'b0;
  logic        reset_n = 1'b1;
  logic        enable = 1'b0;
  logic        seq_out, seq_valid, det_in, clear_count, thresh_hit, busy;
  logic [15:0] threshold, det_count;

  logic        seq_out2, seq_valid2, det2, clr2, hit2, busy2;
  logic [3:0]  thr2, cnt2;

  int errors = 0;
  int checks = 0;
  int run = 0;
  int max_run = 0;
  logic exp_q[$];

  always #5 clock = ~clock;

  seq_stream_ctrl_if #(.WORD_W(8)) s_if ();
  seq_stream_ctrl_if #(.WORD_W(8)) s_if2 ();

  seq_stream_ctrl #(.WORD_W(8), .CNT_W(16)) dut (
    .clock(clock), .reset_n(reset_n), .enable(enable), .s_if(s_if),
    .seq_out(seq_out), .seq_valid(seq_valid), .det_in(det_in),
    .threshold(threshold), .clear_count(clear_count),
    .det_count(det_count), .thresh_hit(thresh_hit), .busy(busy)
  );

  // Narrow-counter instance kept permanently streaming so its counter is always enabled.
  assign s_if2.in_valid = 1'b1;
  assign s_if2.in_data  = 8'hFF;
  seq_stream_ctrl #(.WORD_W(8), .CNT_W(4)) dut2 (
    .clock(clock), .reset_n(reset_n), .enable(1'b1), .s_if(s_if2),
    .seq_out(seq_out2), .seq_valid(seq_valid2), .det_in(det2),
    .threshold(thr2), .clear_count(clr2),
    .det_count(cnt2), .thresh_hit(hit2), .busy(busy2)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Offer a word, wait (bounded) for in_ready, handshake on the next edge.
  task automatic send(input logic [7:0] d, input bit push, output int waits);
    waits = 0;
    s_if.in_valid = 1'b1;
    s_if.in_data  = d;
    while (!s_if.in_ready && waits < 50) begin
      tick();
      waits++;
    end
    if (!s_if.in_ready) check("in_ready_timeout", 0, 1);
    if (push) for (int i = 7; i >= 0; i--) exp_q.push_back(d[i]);
    tick();
    s_if.in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 50) begin
      tick();
      n++;
    end
    check("idle_timeout", busy, 0);
  endtask

  always @(negedge clock) begin
    if (seq_valid) begin
      run++;
      if (run > max_run) max_run = run;
      if (exp_q.size() == 0) check("stream_extra_bit", 1, 0);
      else check("stream_bit", seq_out, exp_q.pop_front());
    end else begin
      run = 0;
    end
  end

  initial begin
    int w;
    s_if.in_valid = 1'b0;
    s_if.in_data  = '0;
    det_in = 0; clear_count = 0; threshold = 16'd3;
    det2 = 0; clr2 = 0; thr2 = 4'd10;
    enable = 1'b1;
    #1 reset_n = 1'b0;
    #2;
    check("rst_in_ready", s_if.in_ready, 0);
    check("rst_seq_valid", seq_valid, 0);
    check("rst_seq_out", seq_out, 0);
    check("rst_busy", busy, 0);
    check("rst_det_count", det_count, 0);
    check("rst_thresh_hit", thresh_hit, 0);
    #19 reset_n = 1'b1;

    // V1: single word, then one DRAIN cycle
    max_run = 0;
    send(8'b1011_0010, 1'b1, w);
    check("v1_first_hs_edge", w, 1);
    repeat (8) tick();
    check("v1_drain_busy", busy, 1);
    check("v1_drain_valid", seq_valid, 0);
    check("v1_drain_ready", s_if.in_ready, 0);
    tick();
    check("v1_idle_busy", busy, 0);
    check("v1_idle_ready", s_if.in_ready, 1);
    check("v1_run", max_run, 8);

    // V2: back-to-back words, in_ready only on the last bit
    max_run = 0;
    send(8'hA5, 1'b1, w);
    check("v2_w0_wait", w, 0);
    send(8'h3C, 1'b1, w);
    check("v2_w1_wait", w, 7);
    wait_idle();
    check("v2_run", max_run, 16);

    // V3: three detections in SHIFT, one ignored in IDLE
    send(8'h00, 1'b1, w);
    det_in = 1'b1;
    tick();
    check("v3_cnt1", det_count, 1);
    check("v3_hit1", thresh_hit, 0);
    tick();
    check("v3_cnt2", det_count, 2);
    check("v3_hit2", thresh_hit, 0);
    tick();
    check("v3_cnt3", det_count, 3);
    check("v3_hit3", thresh_hit, 1);
    det_in = 1'b0;
    wait_idle();
    det_in = 1'b1;
    tick();
    det_in = 1'b0;
    check("v3_idle_ignored", det_count, 3);
    check("v3_hit_sticky", thresh_hit, 1);
    clear_count = 1'b1;
    tick();
    clear_count = 1'b0;
    check("v3_clr_cnt", det_count, 0);
    check("v3_clr_hit", thresh_hit, 0);

    // V4: 4-bit counter saturation and clear priority
    check("v4_busy", busy2, 1);
    det2 = 1'b1;
    repeat (15) tick();
    check("v4_cnt15", cnt2, 15);
    repeat (2) tick();
    check("v4_saturate", cnt2, 15);
    check("v4_hit", hit2, 1);
    clr2 = 1'b1;
    tick();
    clr2 = 1'b0;
    det2 = 1'b0;
    check("v4_clr_cnt", cnt2, 0);
    check("v4_clr_hit", hit2, 0);

    // V5: reset after three bits of 0xFF, then 0x80 starts at MSB
    send(8'hFF, 1'b0, w);
    repeat (3) exp_q.push_back(1'b1);
    repeat (2) tick();
    @(negedge clock);
    #1 reset_n = 1'b0;
    #1;
    check("v5_rst_valid", seq_valid, 0);
    check("v5_rst_out", seq_out, 0);
    check("v5_rst_busy", busy, 0);
    check("v5_rst_ready", s_if.in_ready, 0);
    #2 reset_n = 1'b1;
    send(8'h80, 1'b1, w);
    check("v5_first_hs_edge", w, 1);
    wait_idle();

    // V6: enable dropped mid-word
    send(8'h0F, 1'b1, w);
    tick();
    enable = 1'b0;
    s_if.in_valid = 1'b1;
    s_if.in_data  = 8'hAA;
    repeat (6) tick();
    check("v6_last_valid", seq_valid, 1);
    check("v6_last_ready", s_if.in_ready, 0);
    tick();
    check("v6_drain_busy", busy, 1);
    check("v6_drain_valid", seq_valid, 0);
    tick();
    check("v6_idle_busy", busy, 0);
    check("v6_idle_ready", s_if.in_ready, 0);
    s_if.in_valid = 1'b0;
    repeat (3) tick();
    check("scoreboard_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
